// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: FSM states, opcode/funct
// values and the datapath mux/ALU select codes. TRAP exists only under CTRL_OVF_TRAP_EN.
package ctrl_pkg;

`ifdef CTRL_OVF_TRAP_EN
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_e;
`else
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP
  } state_e;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

  // Only arithmetic R-type ops can raise a signed overflow.
  function automatic logic is_add_sub(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB);
  endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// R-type funct field to ALU operation decode; unsupported functs fall back to ADD.
module ctrl_alu_dec
  import ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);

  always_comb begin
    case (funct)
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback FSM driving the
// datapath selects and enables. Define CTRL_OVF_TRAP_EN to enable overflow/illegal-opcode traps.
module mc_ctrl_seq
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       pc_write,
  output logic       aluout_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic       epc_write,
  output logic       alusrca_sel,
  output logic [1:0] alusrcb_sel,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg
);

  state_e     state_q, state_d;
  logic [2:0] funct_alu_op;

  ctrl_alu_dec u_alu_dec (
    .funct  (funct),
    .alu_op (funct_alu_op)
  );

`ifndef CTRL_OVF_TRAP_EN
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  // Outputs decode straight from state_q, so an async reset zeroes them immediately.
  always_comb begin
    // NOTE: every output and state_d gets a default first so no path infers a latch.
    state_d      = state_q;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    aluout_write = 1'b0;
    mdr_write    = 1'b0;
    reg_write    = 1'b0;
    epc_write    = 1'b0;
    alusrca_sel  = 1'b0;
    alusrcb_sel  = SRCB_REGB;
    alu_op       = ALU_ADD;
    pc_src       = PC_ALU;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        mem_rd      = 1'b1;
        alusrcb_sel = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alusrcb_sel  = SRCB_IMM;
        aluout_write = 1'b1;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef CTRL_OVF_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end

      S_EXEC_R: begin
        alusrca_sel  = 1'b1;
        alu_op       = funct_alu_op;
        aluout_write = 1'b1;
`ifdef CTRL_OVF_TRAP_EN
        state_d = (overflow && is_add_sub(funct)) ? S_TRAP : S_WB_R;
`else
        state_d = S_WB_R;
`endif
      end

      S_EXEC_I: begin
        alusrca_sel  = 1'b1;
        alusrcb_sel  = SRCB_IMM;
        aluout_write = 1'b1;
`ifdef CTRL_OVF_TRAP_EN
        state_d = overflow ? S_TRAP : S_WB_I;
`else
        state_d = S_WB_I;
`endif
      end

      S_MEM_ADDR: begin
        alusrca_sel  = 1'b1;
        alusrcb_sel  = SRCB_IMM;
        aluout_write = 1'b1;
        state_d      = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) begin
          mdr_write = 1'b1;
          state_d   = S_WB_MEM;
        end
      end

      S_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_WB_R: begin
        reg_write = 1'b1;
        regdst    = 1'b1;
        state_d   = S_FETCH;
      end

      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_WB_MEM: begin
        reg_write = 1'b1;
        memtoreg  = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alusrca_sel = 1'b1;
        alu_op      = ALU_SUB;
        pc_src      = PC_ALUOUT;
        pc_write    = zero;
        state_d     = S_FETCH;
      end

      S_JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end

`ifdef CTRL_OVF_TRAP_EN
      S_TRAP: begin
        epc_write = 1'b1;
        pc_src    = PC_TRAP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
`endif

      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Directed bench for mc_ctrl_seq: walks each instruction class cycle by cycle and
// compares the full control word against hand-written expectations.
module tb_mc_ctrl_seq;

  logic       clk, reset_n;
  logic [5:0] opcode, funct;
  logic       zero, overflow, mem_ready;
  logic       mem_rd, mem_wr, ir_write, pc_write, aluout_write, mdr_write;
  logic       reg_write, epc_write, alusrca_sel, iord, regdst, memtoreg;
  logic [1:0] alusrcb_sel, pc_src;
  logic [2:0] alu_op;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       pc_write;
    logic       aluout_write;
    logic       mdr_write;
    logic       reg_write;
    logic       epc_write;
    logic       alusrca_sel;
    logic [1:0] alusrcb_sel;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
  } ctl_t;

  ctl_t obs;
  assign obs = {mem_rd, mem_wr, ir_write, pc_write, aluout_write, mdr_write,
                reg_write, epc_write, alusrca_sel, alusrcb_sel, alu_op, pc_src,
                iord, regdst, memtoreg};

  localparam ctl_t E_ZERO      = '{default: 0};
  localparam ctl_t E_FETCH_RDY = '{mem_rd: 1, ir_write: 1, pc_write: 1, alusrcb_sel: 2'b01, default: 0};
  localparam ctl_t E_FETCH_WT  = '{mem_rd: 1, alusrcb_sel: 2'b01, default: 0};
  localparam ctl_t E_DECODE    = '{aluout_write: 1, alusrcb_sel: 2'b10, default: 0};
  localparam ctl_t E_EXR_ADD   = '{aluout_write: 1, alusrca_sel: 1, default: 0};
  localparam ctl_t E_EXR_SUB   = '{aluout_write: 1, alusrca_sel: 1, alu_op: 3'b001, default: 0};
  localparam ctl_t E_EXR_AND   = '{aluout_write: 1, alusrca_sel: 1, alu_op: 3'b010, default: 0};
  localparam ctl_t E_EXR_OR    = '{aluout_write: 1, alusrca_sel: 1, alu_op: 3'b011, default: 0};
  localparam ctl_t E_EXI       = '{aluout_write: 1, alusrca_sel: 1, alusrcb_sel: 2'b10, default: 0};
  localparam ctl_t E_WB_R      = '{reg_write: 1, regdst: 1, default: 0};
  localparam ctl_t E_WB_I      = '{reg_write: 1, default: 0};
  localparam ctl_t E_WB_MEM    = '{reg_write: 1, memtoreg: 1, default: 0};
  localparam ctl_t E_MRD_WT    = '{mem_rd: 1, iord: 1, default: 0};
  localparam ctl_t E_MRD_RDY   = '{mem_rd: 1, iord: 1, mdr_write: 1, default: 0};
  localparam ctl_t E_MWR       = '{mem_wr: 1, iord: 1, default: 0};
  localparam ctl_t E_BR_T      = '{alusrca_sel: 1, alu_op: 3'b001, pc_src: 2'b01, pc_write: 1, default: 0};
  localparam ctl_t E_BR_NT     = '{alusrca_sel: 1, alu_op: 3'b001, pc_src: 2'b01, default: 0};
  localparam ctl_t E_JUMP      = '{pc_src: 2'b10, pc_write: 1, default: 0};
  localparam ctl_t E_TRAP      = '{epc_write: 1, pc_src: 2'b11, pc_write: 1, default: 0};

  int n_cmp = 0;
  int n_err = 0;

  mc_ctrl_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .overflow     (overflow),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .aluout_write (aluout_write),
    .mdr_write    (mdr_write),
    .reg_write    (reg_write),
    .epc_write    (epc_write),
    .alusrca_sel  (alusrca_sel),
    .alusrcb_sel  (alusrcb_sel),
    .alu_op       (alu_op),
    .pc_src       (pc_src),
    .iord         (iord),
    .regdst       (regdst),
    .memtoreg     (memtoreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input ctl_t exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // Inputs are set 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic step(input string tag, input ctl_t exp);
    #2;
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'h00; funct = 6'h00;
    zero = 1'b0; overflow = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    #2 check("in_reset", E_ZERO);
    reset_n = 1'b1;
    step("rst_state", E_ZERO);

    // R-type add, sub, and, or, plus an unsupported funct that executes as ADD
    opcode = 6'h00; funct = 6'h20;
    step("add_fetch", E_FETCH_RDY);
    step("add_decode", E_DECODE);
    step("add_exec", E_EXR_ADD);
    step("add_wb", E_WB_R);
    funct = 6'h22;
    step("sub_fetch", E_FETCH_RDY);
    step("sub_decode", E_DECODE);
    step("sub_exec", E_EXR_SUB);
    step("sub_wb", E_WB_R);
    funct = 6'h24;
    step("and_fetch", E_FETCH_RDY);
    step("and_decode", E_DECODE);
    step("and_exec", E_EXR_AND);
    step("and_wb", E_WB_R);
    funct = 6'h25;
    step("or_fetch", E_FETCH_RDY);
    step("or_decode", E_DECODE);
    step("or_exec", E_EXR_OR);
    step("or_wb", E_WB_R);
    funct = 6'h27;
    step("unk_fn_fetch", E_FETCH_RDY);
    step("unk_fn_decode", E_DECODE);
    step("unk_fn_exec", E_EXR_ADD);
    step("unk_fn_wb", E_WB_R);

    // lw with two memory wait cycles: seven cycles in total
    opcode = 6'h23; funct = 6'h00;
    step("lw_fetch", E_FETCH_RDY);
    step("lw_decode", E_DECODE);
    step("lw_addr", E_EXI);
    mem_ready = 1'b0;
    step("lw_rd_wait1", E_MRD_WT);
    step("lw_rd_wait2", E_MRD_WT);
    mem_ready = 1'b1;
    step("lw_rd_done", E_MRD_RDY);
    step("lw_wb", E_WB_MEM);

    // sw with one fetch wait cycle
    opcode = 6'h2B;
    mem_ready = 1'b0;
    step("sw_fetch_wait", E_FETCH_WT);
    mem_ready = 1'b1;
    step("sw_fetch", E_FETCH_RDY);
    step("sw_decode", E_DECODE);
    step("sw_addr", E_EXI);
    step("sw_wr", E_MWR);

    // beq taken and not taken
    opcode = 6'h04; zero = 1'b1;
    step("beq_t_fetch", E_FETCH_RDY);
    step("beq_t_decode", E_DECODE);
    step("beq_t_branch", E_BR_T);
    zero = 1'b0;
    step("beq_nt_fetch", E_FETCH_RDY);
    step("beq_nt_decode", E_DECODE);
    step("beq_nt_branch", E_BR_NT);

    // j
    opcode = 6'h02;
    step("j_fetch", E_FETCH_RDY);
    step("j_decode", E_DECODE);
    step("j_jump", E_JUMP);

    // addi with overflow
    opcode = 6'h08; overflow = 1'b1;
    step("addi_fetch", E_FETCH_RDY);
    step("addi_decode", E_DECODE);
    step("addi_exec", E_EXI);
`ifdef CTRL_OVF_TRAP_EN
    step("addi_ovf_trap", E_TRAP);
`else
    step("addi_ovf_wb", E_WB_I);
`endif
    overflow = 1'b0;

    // unknown opcode
    opcode = 6'h3F;
    step("unk_op_fetch", E_FETCH_RDY);
    step("unk_op_decode", E_DECODE);
`ifdef CTRL_OVF_TRAP_EN
    step("unk_op_trap", E_TRAP);
`endif

    // sw interrupted by an asynchronous reset while waiting on memory
    opcode = 6'h2B;
    step("rst_sw_fetch", E_FETCH_RDY);
    step("rst_sw_decode", E_DECODE);
    step("rst_sw_addr", E_EXI);
    mem_ready = 1'b0;
    #2 check("rst_sw_wr", E_MWR);
    #1 reset_n = 1'b0;
    #1 check("rst_async_drop", E_ZERO);
    @(posedge clk);
    #1;
    #2 check("rst_held", E_ZERO);
    reset_n = 1'b1; mem_ready = 1'b1;
    step("rst_restart", E_ZERO);
    step("rst_refetch", E_FETCH_RDY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
